bcd_para_binario: RTL and testbench
===================================

# bcd_para_binario

Sequential BCD-to-binary converter: accepts a sign flag and four BCD digits (milhar, centena, dezena, unidade) and produces the equivalent 32-bit two's-complement word. It is the inverse of the binary-to-4-digit-BCD display path. It sits between the keypad/switch input logic and the processor's input instruction datapath. Conversion uses reverse double-dabble, one shift per clock, with a start/pronto handshake.

## Interface
- No parameters; widths fixed (4 digits, 32-bit result).
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a conversion; sampled only in OCIOSO
- sinal  input  1  sign of the input number (1 = negative)
- milhar  input  4  thousands digit, BCD
- centena  input  4  hundreds digit, BCD
- dezena  input  4  tens digit, BCD
- unidade  input  4  units digit, BCD
- numero  output  32  converted two's-complement result, held until the next accepted start
- pronto  output  1  one-cycle pulse: numero/erro valid
- ocupado  output  1  high while a conversion is in progress
- erro  output  1  last accepted request had a digit > 9

## Operation
- States: OCIOSO, CONVERTE, SINAL.
- Internal registers:
  - bcd[15:0] = {milhar, centena, dezena, unidade}
  - bin[15:0] accumulator
  - cont[4:0] shift counter
  - sinal_r captured sign
- OCIOSO, start=1, all digits ≤ 9:
  - capture digits into bcd and sinal into sinal_r; bin←0, cont←0
  - erro←0; go to CONVERTE.
- OCIOSO, start=1, any digit ≥ 10:
  - numero←0, erro←1, pronto←1; stay in OCIOSO; no conversion.
- CONVERTE, each cycle:
  - {bcd,bin} ← {bcd,bin} >> 1 (bcd[0] enters bin[15]).
  - Then every bcd nibble whose post-shift value ≥ 8 is decremented by 3 in the same cycle.
  - cont←cont+1. After the 16th shift (cont was 15), go to SINAL.
- SINAL:
  - numero ← sinal_r ? −{16'b0,bin} : {16'b0,bin} (32-bit two's complement).
  - pronto←1; go to OCIOSO.
- Sign of zero: −0 produces 0x00000000. No negative-zero encoding exists.
- Range: result magnitude 0..9999, so numero lies in −9999..+9999. No overflow is possible.
- start in CONVERTE/SINAL is ignored. It is not queued.
- Inputs are captured at acceptance. Changes on sinal or the digit inputs afterwards do not affect the running conversion.
- ocupado = 1 exactly in CONVERTE and SINAL (registered state decode).

## Timing
- Reset values: state OCIOSO, numero 0x00000000, pronto 0, ocupado 0, erro 0, bcd/bin/cont/sinal_r 0.
- Valid request, accepted at edge E0:
  - ocupado high from E0 to E17.
  - Shifts occur at edges E1..E16.
  - numero updates and pronto rises at E17.
  - pronto falls at E18.
  - Latency from start sample to pronto: 17 cycles.
- Invalid request, accepted at E0: numero, erro and pronto update at E0; pronto falls at E1. Latency 0 cycles, ocupado stays 0.
- start held high continuously: a new request is accepted at the first edge back in OCIOSO (E18 for a valid request). Throughput is one conversion per 18 cycles.
- erro stays valid until the next accepted start.
- Reset mid-conversion, at any edge: forces all reset values at that edge. The conversion is aborted, no pronto pulse occurs, and numero reads 0.
- reset and start high on the same edge: reset wins; the request is dropped.

## Test plan
- Positive value:
  - Stimulus: sinal=0, digits 1,2,3,4, start one cycle.
  - Required: numero=0x000004D2 with pronto exactly 17 cycles after the start sample; ocupado high 17 cycles; erro=0.
- Negative value:
  - Stimulus: sinal=1, digits 0,5,0,0.
  - Required: numero=0xFFFFFE0C.
- Extremes:
  - 9999 positive → 0x0000270F.
  - 9999 negative → 0xFFFFD8F1.
  - 0000 with sinal=1 → 0x00000000.
- Invalid digit:
  - Stimulus: centena=4'hA, others valid.
  - Required: pronto at the start sample edge with erro=1, numero=0, ocupado never high. The next valid request must then clear erro.
- Busy and capture:
  - Stimulus: during conversion of 0042, pulse start with digits 0,0,9,9 and change the digit inputs.
  - Required: the second start is ignored, the result is 0x0000002A, and one pronto only.
- Reset abort:
  - Stimulus: assert reset for one cycle after the 8th shift of 1234.
  - Required: all outputs 0 on the following cycle and no pronto. A later request for 0007 returns 0x00000007.

Source files
------------

// File: rtl/bcd_para_binario.sv
// Sequential BCD-to-binary converter: four BCD digits plus sign become a 32-bit
// two's-complement word using reverse double-dabble, one shift per clock.
module bcd_para_binario (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        sinal,
    input  logic [3:0]  milhar,
    input  logic [3:0]  centena,
    input  logic [3:0]  dezena,
    input  logic [3:0]  unidade,
    output logic [31:0] numero,
    output logic        pronto,
    output logic        ocupado,
    output logic        erro
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        SINAL    = 2'd2
    } estado_t;

    estado_t     estado, estado_next;
    logic [15:0] bcd, bcd_next;
    logic [15:0] bin, bin_next;
    logic [4:0]  cont, cont_next;
    logic        sinal_r, sinal_r_next;
    logic [31:0] numero_next;
    logic        pronto_next;
    logic        erro_next;

    logic        digitos_validos;
    logic [31:0] deslocado;
    logic [15:0] bcd_ajustado;
    logic [31:0] magnitude;

    // After a right shift a nibble >= 8 means a "10" crossed into it; subtracting 3 undoes the carry weighting.
    function automatic logic [3:0] ajusta(input logic [3:0] n);
        return (n >= 4'd8) ? (n - 4'd3) : n;
    endfunction

    assign digitos_validos = (milhar <= 4'd9) && (centena <= 4'd9) &&
                             (dezena <= 4'd9) && (unidade <= 4'd9);

    assign deslocado    = {bcd, bin} >> 1;
    assign bcd_ajustado = {ajusta(deslocado[31:28]), ajusta(deslocado[27:24]),
                           ajusta(deslocado[23:20]), ajusta(deslocado[19:16])};
    assign magnitude    = {16'd0, bin};

    always_comb begin
        estado_next  = estado;
        bcd_next     = bcd;
        bin_next     = bin;
        cont_next    = cont;
        sinal_r_next = sinal_r;
        numero_next  = numero;
        erro_next    = erro;
        pronto_next  = 1'b0;

        unique case (estado)
            OCIOSO: begin
                if (start) begin
                    if (digitos_validos) begin
                        bcd_next     = {milhar, centena, dezena, unidade};
                        bin_next     = 16'd0;
                        cont_next    = 5'd0;
                        sinal_r_next = sinal;
                        erro_next    = 1'b0;
                        estado_next  = CONVERTE;
                    end else begin
                        numero_next = 32'd0;
                        erro_next   = 1'b1;
                        pronto_next = 1'b1;
                    end
                end
            end
            CONVERTE: begin
                bcd_next  = bcd_ajustado;
                bin_next  = deslocado[15:0];
                cont_next = cont + 5'd1;
                if (cont == 5'd15) begin
                    estado_next = SINAL;
                end
            end
            SINAL: begin
                numero_next = sinal_r ? (32'd0 - magnitude) : magnitude;
                pronto_next = 1'b1;
                estado_next = OCIOSO;
            end
            default: begin
                estado_next = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= OCIOSO;
            bcd     <= 16'd0;
            bin     <= 16'd0;
            cont    <= 5'd0;
            sinal_r <= 1'b0;
            numero  <= 32'd0;
            pronto  <= 1'b0;
            erro    <= 1'b0;
        end else begin
            estado  <= estado_next;
            bcd     <= bcd_next;
            bin     <= bin_next;
            cont    <= cont_next;
            sinal_r <= sinal_r_next;
            numero  <= numero_next;
            pronto  <= pronto_next;
            erro    <= erro_next;
        end
    end

    assign ocupado = (estado != OCIOSO);

endmodule

// File: tb/tb_bcd_para_binario.sv
// Directed testbench for bcd_para_binario: hand-computed results, latency,
// busy/ignore behaviour, invalid digits and reset abort.
module tb_bcd_para_binario;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        sinal;
    logic [3:0]  milhar, centena, dezena, unidade;
    logic [31:0] numero;
    logic        pronto, ocupado, erro;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int cycAccept = 0;
    int prontoCount = 0;
    int ocupadoCount = 0;
    int prontoBase, ocupadoBase, lat;

    bcd_para_binario dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .sinal   (sinal),
        .milhar  (milhar),
        .centena (centena),
        .dezena  (dezena),
        .unidade (unidade),
        .numero  (numero),
        .pronto  (pronto),
        .ocupado (ocupado),
        .erro    (erro)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse/busy counters sampled mid-cycle, away from the active edge
    always @(negedge clock) begin
        if (pronto)  prontoCount++;
        if (ocupado) ocupadoCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] m, input logic [3:0] c,
                                 input logic [3:0] d, input logic [3:0] u);
        sinal = s; milhar = m; centena = c; dezena = d; unidade = u;
        start = 1'b1;
        prontoBase  = prontoCount;
        ocupadoBase = ocupadoCount;
        @(posedge clock);
        #1;
        start = 1'b0;
        cycAccept = cyc;
    endtask

    task automatic waitPronto(output int latency);
        latency = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (pronto) begin
                latency = cyc - cycAccept;
                break;
            end
        end
    endtask

    task automatic runValid(input string tag, input logic s, input logic [3:0] m, input logic [3:0] c,
                            input logic [3:0] d, input logic [3:0] u, input logic [31:0] expected);
        applyStimulus(s, m, c, d, u);
        waitPronto(lat);
        checkOutput({tag, "_latency"}, lat, 32'd17);
        checkOutput({tag, "_numero"}, numero, expected);
        checkOutput({tag, "_erro"}, {31'd0, erro}, 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sinal = 1'b0;
        milhar = 4'd0; centena = 4'd0; dezena = 4'd0; unidade = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_numero", numero, 32'd0);
        checkOutput("reset_flags", {29'd0, pronto, ocupado, erro}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // 1234 positive, full timing checks
        applyStimulus(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        checkOutput("pos_ocupado_e0", {31'd0, ocupado}, 32'd1);
        waitPronto(lat);
        checkOutput("pos_latency", lat, 32'd17);
        checkOutput("pos_numero", numero, 32'h000004D2);
        checkOutput("pos_erro", {31'd0, erro}, 32'd0);
        checkOutput("pos_ocupado_e17", {31'd0, ocupado}, 32'd0);
        @(posedge clock);
        #1;
        checkOutput("pos_pronto_fall", {31'd0, pronto}, 32'd0);
        checkOutput("pos_ocupado_cycles", ocupadoCount - ocupadoBase, 32'd17);
        checkOutput("pos_pronto_count", prontoCount - prontoBase, 32'd1);

        runValid("neg500", 1'b1, 4'd0, 4'd5, 4'd0, 4'd0, 32'hFFFFFE0C);
        runValid("pos9999", 1'b0, 4'd9, 4'd9, 4'd9, 4'd9, 32'h0000270F);
        runValid("neg9999", 1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 32'hFFFFD8F1);
        runValid("negzero", 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 32'h00000000);

        // Invalid digit: immediate error response
        applyStimulus(1'b0, 4'd1, 4'hA, 4'd3, 4'd4);
        checkOutput("inv_pronto", {31'd0, pronto}, 32'd1);
        checkOutput("inv_erro", {31'd0, erro}, 32'd1);
        checkOutput("inv_numero", numero, 32'd0);
        checkOutput("inv_ocupado", {31'd0, ocupado}, 32'd0);
        @(posedge clock);
        #1;
        checkOutput("inv_pronto_fall", {31'd0, pronto}, 32'd0);
        checkOutput("inv_erro_hold", {31'd0, erro}, 32'd1);
        checkOutput("inv_ocupado_cycles", ocupadoCount - ocupadoBase, 32'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd1);
        checkOutput("inv_erro_cleared", {31'd0, erro}, 32'd0);
        waitPronto(lat);
        checkOutput("after_inv_numero", numero, 32'd1);
        @(posedge clock);
        #1;

        // Busy: second start ignored, inputs changed after capture
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd4, 4'd2);
        repeat (3) @(posedge clock);
        #1;
        milhar = 4'd0; centena = 4'd0; dezena = 4'd9; unidade = 4'd9; sinal = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        milhar = 4'd8; centena = 4'd7; dezena = 4'd6; unidade = 4'd5;
        waitPronto(lat);
        checkOutput("busy_latency", lat, 32'd17);
        checkOutput("busy_numero", numero, 32'h0000002A);
        repeat (25) @(posedge clock);
        #1;
        checkOutput("busy_pronto_count", prontoCount - prontoBase, 32'd1);
        checkOutput("busy_idle", {31'd0, ocupado}, 32'd0);

        // Reset abort after the 8th shift
        applyStimulus(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        repeat (8) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("abort_numero", numero, 32'd0);
        checkOutput("abort_flags", {29'd0, pronto, ocupado, erro}, 32'd0);
        repeat (20) @(posedge clock);
        #1;
        checkOutput("abort_no_pronto", prontoCount - prontoBase, 32'd0);
        runValid("after_abort", 1'b0, 4'd0, 4'd0, 4'd0, 4'd7, 32'h00000007);

        // Reset and start on the same edge: request dropped
        sinal = 1'b0; milhar = 4'd0; centena = 4'd0; dezena = 4'd5; unidade = 4'd5;
        reset = 1'b1;
        start = 1'b1;
        prontoBase = prontoCount;
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        checkOutput("rst_start_ocupado", {31'd0, ocupado}, 32'd0);
        repeat (20) @(posedge clock);
        #1;
        checkOutput("rst_start_no_pronto", prontoCount - prontoBase, 32'd0);
        checkOutput("rst_start_numero", numero, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
